// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch slice.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_ERR   = 2'd3
    } fetch_state_e;

    localparam logic [31:0] PC_INCR     = 32'd4;
    localparam logic [31:0] RESET_INSTR = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jr > jump > branch > sequential, all modulo 2^ADDR_W.
module next_pc_calc
    import mips_fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              branch_taken,
    input  logic [15:0]       branch_imm,
    input  logic              jump,
    input  logic [25:0]       jump_idx,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] seq_s;
    logic [ADDR_W-1:0] branch_off_s;
    logic [ADDR_W-1:0] branch_tgt_s;
    logic [ADDR_W-1:0] jump_tgt_s;

    assign seq_s        = pc_in + PC_INCR[ADDR_W-1:0];
    assign branch_off_s = {{(ADDR_W-18){branch_imm[15]}}, branch_imm, 2'b00};
    assign branch_tgt_s = seq_s + branch_off_s;
    assign jump_tgt_s   = {seq_s[ADDR_W-1:28], jump_idx, 2'b00};

    // Priority mux over the candidate targets.
    always_comb begin
        target = seq_s;
        if (jr) begin
            target = jr_addr;
        end else if (jump) begin
            target = jump_tgt_s;
        end else if (branch_taken) begin
            target = branch_tgt_s;
        end else begin
            target = seq_s;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch controller: IDLE/FETCH/ISSUE handshake, instruction register, next-PC drive.
// Optional fetch timeout with sticky error is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] pc_bar,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              branch_taken,
    input  logic [15:0]       branch_imm,
    input  logic              jump,
    input  logic [25:0]       jump_idx,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic              fetch_err
);

    fetch_state_e      state_r;
    logic              mem_req_r;
    logic [DATA_W-1:0] instr_r;
    logic              instr_valid_r;
    logic [ADDR_W-1:0] target_s;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0]  tmo_cnt_r;
    logic              fetch_err_r;
`endif

    next_pc_calc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .pc_in        (pc_in),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_idx     (jump_idx),
        .jr           (jr),
        .jr_addr      (jr_addr),
        .target       (target_s)
    );

    // The PC register has no enable, so every state except ISSUE holds it by feeding pc_in back.
    always_comb begin
        pc_bar = pc_in;
        if (state_r == ST_ISSUE) begin
            pc_bar = target_s;
        end else begin
            pc_bar = pc_in;
        end
    end

    assign mem_addr    = {pc_in[ADDR_W-1:2], 2'b00};
    assign mem_req     = mem_req_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;

    // Fetch FSM with registered handshake, instruction register and optional timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            mem_req_r     <= 1'b0;
            instr_r       <= RESET_INSTR[DATA_W-1:0];
            instr_valid_r <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt_r     <= {CNT_W{1'b0}};
            fetch_err_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r       <= ST_FETCH;
                    mem_req_r     <= 1'b1;
                    instr_valid_r <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    tmo_cnt_r     <= {CNT_W{1'b0}};
`endif
                end
                ST_FETCH: begin
                    if (mem_req_r && mem_ready) begin
                        instr_r       <= mem_rdata;
                        state_r       <= ST_ISSUE;
                        mem_req_r     <= 1'b0;
                        instr_valid_r <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    end else if (tmo_cnt_r == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state_r       <= ST_ERR;
                        mem_req_r     <= 1'b0;
                        instr_valid_r <= 1'b0;
                        fetch_err_r   <= 1'b1;
                        tmo_cnt_r     <= tmo_cnt_r + 1'b1;
                    end else begin
                        instr_valid_r <= 1'b0;
                        tmo_cnt_r     <= tmo_cnt_r + 1'b1;
                    end
`else
                    end else begin
                        instr_valid_r <= 1'b0;
                    end
`endif
                end
                ST_ISSUE: begin
                    state_r       <= ST_FETCH;
                    mem_req_r     <= 1'b1;
                    instr_valid_r <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    tmo_cnt_r     <= {CNT_W{1'b0}};
`endif
                end
`ifdef FETCH_TIMEOUT_EN
                ST_ERR: begin
                    state_r       <= ST_ERR;
                    mem_req_r     <= 1'b0;
                    instr_valid_r <= 1'b0;
                    fetch_err_r   <= 1'b1;
                end
`endif
                default: begin
                    state_r       <= ST_IDLE;
                    mem_req_r     <= 1'b0;
                    instr_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_TIMEOUT_EN
    assign fetch_err = fetch_err_r;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; timeout scenario runs when FETCH_TIMEOUT_EN is defined.
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic [31:0] pc_in;
    logic [31:0] pc_bar;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_idx;
    logic        jr;
    logic [31:0] jr_addr;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    fetch_unit #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pc_in        (pc_in),
        .pc_bar       (pc_bar),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_idx     (jump_idx),
        .jr           (jr),
        .jr_addr      (jr_addr),
        .fetch_err    (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        branch_taken = 1'b0; branch_imm = 16'h0000;
        jump = 1'b0; jump_idx = 26'h0; jr = 1'b0; jr_addr = 32'h0;
    endtask

    // From a FETCH cycle: accept with zero wait and land in ISSUE.
    task automatic accept_now(input logic [31:0] data);
        mem_ready = 1'b1; mem_rdata = data;
        step();
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; pc_in = 32'h0; mem_ready = 1'b1; mem_rdata = 32'h2008_0005;
        clear_ctrl();
        step(); step();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", fetch_err); end
        reset_n = 1'b1;
        #1;
        total++; if (pc_bar !== 32'h0) begin bad++; $display("FAIL idle_pc_bar got=%h exp=0", pc_bar); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL idle_mem_req got=%b exp=0", mem_req); end
    endtask

    task automatic test_zero_wait();
        step();
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL zw_mem_req got=%b exp=1", mem_req); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL zw_mem_addr got=%h exp=0", mem_addr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL zw_early_valid got=%b exp=0", instr_valid); end
        step();
        mem_ready = 1'b0;
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL zw_valid got=%b exp=1", instr_valid); end
        total++; if (instr !== 32'h2008_0005) begin bad++; $display("FAIL zw_instr got=%h exp=20080005", instr); end
        total++; if (pc_bar !== 32'h4) begin bad++; $display("FAIL zw_pc_bar got=%h exp=4", pc_bar); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL zw_issue_req got=%b exp=0", mem_req); end
        step();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL zw_pulse_end got=%b exp=0", instr_valid); end
        total++; if (instr !== 32'h2008_0005) begin bad++; $display("FAIL zw_instr_hold got=%h exp=20080005", instr); end
    endtask

    // Three wait cycles then accept; pc_in deliberately misaligned to exercise forced alignment.
    task automatic test_wait_states();
        int valids = 0;
        pc_in = 32'h0000_0102;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin mem_ready = 1'b1; mem_rdata = 32'hAABB_CCDD; end
            #1;
            total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL ws_mem_req[%0d] got=%b exp=1", i, mem_req); end
            total++; if (mem_addr !== 32'h0000_0100) begin bad++; $display("FAIL ws_mem_addr[%0d] got=%h exp=00000100", i, mem_addr); end
            total++; if (pc_bar !== 32'h0000_0102) begin bad++; $display("FAIL ws_pc_bar[%0d] got=%h exp=00000102", i, pc_bar); end
            if (instr_valid === 1'b1) valids++;
            step();
        end
        mem_ready = 1'b0;
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL ws_valid got=%b exp=1", instr_valid); end
        total++; if (instr !== 32'hAABB_CCDD) begin bad++; $display("FAIL ws_instr got=%h exp=aabbccdd", instr); end
        total++; if (pc_bar !== 32'h0000_0106) begin bad++; $display("FAIL ws_next_pc got=%h exp=00000106", pc_bar); end
        total++; if (valids !== 0) begin bad++; $display("FAIL ws_extra_valid got=%0d exp=0", valids); end
        step();
    endtask

    task automatic test_branch_jump();
        pc_in = 32'h0040_0010;
        branch_taken = 1'b1; branch_imm = 16'hFFFF;
        #1;
        total++; if (pc_bar !== 32'h0040_0010) begin bad++; $display("FAIL ctrl_ignored got=%h exp=00400010", pc_bar); end
        accept_now(32'h1000_FFFF);
        total++; if (pc_bar !== 32'h0040_0010) begin bad++; $display("FAIL br_neg got=%h exp=00400010", pc_bar); end
        step();
        branch_imm = 16'h0003;
        accept_now(32'h1000_0003);
        total++; if (pc_bar !== 32'h0040_0020) begin bad++; $display("FAIL br_pos got=%h exp=00400020", pc_bar); end
        step();
        clear_ctrl();
        jump = 1'b1; jump_idx = 26'h010_0000;
        accept_now(32'h0810_0000);
        total++; if (pc_bar !== 32'h0040_0000) begin bad++; $display("FAIL jump got=%h exp=00400000", pc_bar); end
        step();
        clear_ctrl();
    endtask

    task automatic test_priority_wrap();
        jr = 1'b1; jump = 1'b1; branch_taken = 1'b1;
        jr_addr = 32'h0000_1000; jump_idx = 26'h010_0000; branch_imm = 16'h0003;
        accept_now(32'h0000_0008);
        total++; if (pc_bar !== 32'h0000_1000) begin bad++; $display("FAIL prio_jr got=%h exp=00001000", pc_bar); end
        step();
        jr = 1'b0;
        accept_now(32'h0000_0008);
        total++; if (pc_bar !== 32'h0040_0000) begin bad++; $display("FAIL prio_jump got=%h exp=00400000", pc_bar); end
        step();
        clear_ctrl();
        pc_in = 32'hFFFF_FFFC;
        accept_now(32'h0000_0000);
        total++; if (pc_bar !== 32'h0000_0000) begin bad++; $display("FAIL wrap got=%h exp=00000000", pc_bar); end
        step();
    endtask

    task automatic test_reset_midfetch();
        pc_in = 32'h0000_0200;
        step(); step();
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL mf_waiting got=%b exp=1", mem_req); end
        reset_n = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mf_req_drop got=%b exp=0", mem_req); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL mf_instr got=%h exp=0", instr); end
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL mf_late_ready got=%b exp=0", instr_valid); end
        reset_n = 1'b1;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mf_idle_req got=%b exp=0", mem_req); end
        step();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL mf_idle_valid got=%b exp=0", instr_valid); end
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL mf_restart got=%b exp=1", mem_req); end
        total++; if (mem_addr !== 32'h0000_0200) begin bad++; $display("FAIL mf_addr got=%h exp=00000200", mem_addr); end
        step();
        mem_ready = 1'b0;
        total++; if (instr_valid !== 1'b1 || instr !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mf_refetch got=%b/%h exp=1/deadbeef", instr_valid, instr); end
        step();
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        reset_n = 1'b0; mem_ready = 1'b0; pc_in = 32'h0000_0300;
        step();
        reset_n = 1'b1;
        step();
        for (int i = 1; i <= 8; i++) begin
            total++; if (fetch_err !== 1'b0 || mem_req !== 1'b1) begin bad++; $display("FAIL tmo_wait[%0d] got=%b/%b exp=0/1", i, fetch_err, mem_req); end
            step();
        end
        total++; if (fetch_err !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b exp=1", fetch_err); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL tmo_req got=%b exp=0", mem_req); end
        mem_ready = 1'b1;
        step(); step();
        total++; if (fetch_err !== 1'b1 || instr_valid !== 1'b0) begin bad++; $display("FAIL tmo_sticky got=%b/%b exp=1/0", fetch_err, instr_valid); end
        total++; if (pc_bar !== 32'h0000_0300) begin bad++; $display("FAIL tmo_pc_bar got=%h exp=00000300", pc_bar); end
        reset_n = 1'b0;
        #1;
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b exp=0", fetch_err); end
        mem_ready = 1'b0;
        step();
        reset_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_branch_jump();
        test_priority_wrap();
        test_reset_midfetch();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
